sar_ctrl: RTL and testbench
===========================

# sar_ctrl

Synchronous successive-approximation controller for the SAR ADC macro. It drives the sampling-switch inverter (SARADC_CELL_INVX0_ASSW) and the per-bit capacitor-DAC drivers (SARADC_CELL_INVX16_ASCAP). It strobes the comparator and resolves one bit per two clocks, MSB first. It sits directly upstream of the analog cell row and presents a registered digital result to the system.

## Interface
- NBITS, 8: conversion resolution. Legal range is 2..16.
- SAMPLE_CYCLES, 2: number of clocks the sampling switch is held closed. Legal range is 1..15.

Ports:
- clk  in  1  conversion clock.
- rst_n  in  1  reset, asynchronous and active-low. This is the block's only clock/reset scheme: one clock, asynchronous active-low reset.
- start  in  1  conversion request. Level-sampled, and accepted only in IDLE.
- comp_out  in  1  comparator decision, synchronous to clk. 1 means input ≥ DAC trial value.
- sample  out  1  sampling-switch enable, registered.
- comp_en  out  1  comparator strobe, registered.
- dac  out  NBITS  capacitor-DAC driver code, registered. Bit NBITS-1 is the MSB capacitor.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when result updates.
- result  out  NBITS  last completed conversion. Held between conversions.

## Operation
States are IDLE, SAMPLE, CMP, EVAL and DONE.
- **IDLE:** all outputs 0 except result (held).
  - start=1 at a rising edge → SAMPLE. The sample counter loads SAMPLE_CYCLES-1 and the bit index loads NBITS-1.
- **SAMPLE:** sample=1, dac=0.
  - The counter decrements each cycle. At 0 → CMP.
  - The trial register is set to 1<<(NBITS-1).
- **CMP:** comp_en=1, dac=trial. Next state is always EVAL.
- **EVAL:** comp_en=0, dac=trial. comp_out is captured at the closing edge.
  - If comp_out=0, clear trial[k].
  - If k>0: set trial[k-1], decrement k, → CMP.
  - If k=0: result ← final trial, → DONE.
- **DONE:** done=1 for this single cycle, dac=0, busy=1. Next state is always IDLE.

Rules:
- start is ignored in every state except IDLE. A start held high through DONE re-triggers at the first IDLE cycle.
- The trial register is exactly NBITS wide, with no carry or wrap.
- The bit index is $clog2(NBITS) bits wide and never underflows, because the k=0 branch exits.
- Reset value of every output is 0, including result. Reset returns the FSM to IDLE.
- rst_n asserted mid-conversion immediately clears sample, comp_en, dac, busy and done. No partial result is written.
- An unreachable state encoding recovers to IDLE on the next clock.

## Timing
- Take start sampled at edge t.
  - sample is high in cycles t+1 .. t+SAMPLE_CYCLES.
  - The bit k pair is CMP at t+SAMPLE_CYCLES+1+2(NBITS-1-k), followed by EVAL.
  - done and the new result appear in cycle t+SAMPLE_CYCLES+2·NBITS+1.
  - busy falls one cycle later.
- Defaults: done arrives 19 cycles after start, and the minimum start-to-start interval is 20 cycles.
- comp_out must be stable for setup before the edge ending EVAL. The comparator therefore has one full clock after the comp_en rise to resolve.
- sample and comp_en are never high in the same cycle.
- dac changes only on edges entering CMP (new trial bit) or leaving EVAL/DONE. It is guaranteed stable throughout every CMP/EVAL pair.

## Structure
- Package sar_pkg holds:
  - the state enum sar_state_e (IDLE, SAMPLE, CMP, EVAL, DONE)
  - the default NBITS and SAMPLE_CYCLES constants
  - a function msb_mask(k) returning 1<<k.
- One sub-module, sar_trial_reg. It holds the NBITS trial register and bit index, with inputs init, step and decision. It outputs trial, last_bit, and the final code.
- The top level holds the FSM, the sample counter and the output registers. All outputs are driven straight from flops, with no combinational paths from comp_out or start to outputs.

## Test plan
Use defaults NBITS=8 and SAMPLE_CYCLES=2. The comparator model is comp_out registered as (vin ≥ dac) at each CMP edge.
- vin=0xA5, one-cycle start → dac trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. done at cycle 19, result=0xA5, busy low at cycle 20.
- vin=0x00 → result=0x00. vin=0xFF → result=0xFF. Both with done at cycle 19.
- start pulsed again at cycles 5 and 18 during conversion → ignored. Exactly one done, and result unchanged until then.
- start held high continuously → back-to-back conversions. done at cycles 19, 39, 59. sample re-asserts at cycle 21.
- rst_n low at cycle 10 for 1 cycle → all outputs 0 asynchronously and result stays 0. A new start completes normally with the correct value.
- Throughout all runs, assert that sample&comp_en is never 1, done is exactly one cycle wide, and dac is stable across every CMP/EVAL pair.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_pkg;

  localparam int SAR_NBITS         = 8;
  localparam int SAR_SAMPLE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CMP    = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } sar_state_e;

  // Widest supported code is 16 bits; callers truncate to their own width.
  function automatic logic [15:0] msb_mask(input int unsigned k);
    return 16'(1) << k;
  endfunction

endpackage

// File: rtl/sar_trial_reg.sv
// Successive-approximation trial register and bit index, resolved one bit per step.
module sar_trial_reg
  import sar_pkg::*;
#(
  parameter int NBITS = SAR_NBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             step,
  input  logic             decision,
  output logic [NBITS-1:0] trial,
  output logic [NBITS-1:0] trial_nxt,
  output logic             last_bit,
  output logic [NBITS-1:0] code
);

  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic [KW-1:0]    k;
  logic [KW-1:0]    km1;
  logic [NBITS-1:0] bit_k;
  logic [NBITS-1:0] bit_km1;
  logic [NBITS-1:0] resolved;

  assign km1      = k - 1'b1;
  assign last_bit = (k == '0);
  assign bit_k    = NBITS'(msb_mask(int'(k)));
  // km1 wraps when k is 0, but the next-bit mask is suppressed on the last bit.
  assign bit_km1  = last_bit ? '0 : NBITS'(msb_mask(int'(km1)));
  assign resolved = decision ? trial : (trial & ~bit_k);
  assign code     = resolved;

  always_comb begin
    trial_nxt = trial;
    if (init) begin
      trial_nxt = NBITS'(msb_mask(NBITS - 1));
    end else if (step) begin
      trial_nxt = resolved | bit_km1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trial <= '0;
      k     <= '0;
    end else begin
      trial <= trial_nxt;
      if (init) begin
        k <= KW'(NBITS - 1);
      end else if (step && !last_bit) begin
        k <= km1;
      end
    end
  end

endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC sequencer: sample, then one compare/evaluate pair per bit, MSB first.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS         = SAR_NBITS,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp_out,
  output logic             sample,
  output logic             comp_en,
  output logic [NBITS-1:0] dac,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output sar_state_e       dbg_state
);

  // Handshake: start is a level request, honoured only in IDLE; done is a
  // one-cycle pulse coincident with result taking the new code.

  sar_state_e       state;
  sar_state_e       state_nxt;
  logic [3:0]       cnt;
  logic             init;
  logic             step;
  logic [NBITS-1:0] trial;
  logic [NBITS-1:0] trial_nxt;
  logic [NBITS-1:0] code;
  logic             last_bit;

  assign dbg_state = state;

  sar_trial_reg #(.NBITS(NBITS)) u_trial (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .step      (step),
    .decision  (comp_out),
    .trial     (trial),
    .trial_nxt (trial_nxt),
    .last_bit  (last_bit),
    .code      (code)
  );

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SAMPLE;
          init      = 1'b1;
        end
      end
      SAMPLE: if (cnt == '0) state_nxt = CMP;
      CMP:    state_nxt = EVAL;
      EVAL: begin
        step      = 1'b1;
        state_nxt = last_bit ? DONE : CMP;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (init) begin
        cnt <= 4'(SAMPLE_CYCLES - 1);
      end else if (state == SAMPLE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample  <= 1'b0;
      comp_en <= 1'b0;
      dac     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      sample  <= (state_nxt == SAMPLE);
      comp_en <= (state_nxt == CMP);
      dac     <= (state_nxt == CMP || state_nxt == EVAL) ? trial_nxt : '0;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      if (step && last_bit) begin
        result <= code;
      end
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: table vectors, random codes, reset and back-to-back sequences.
module tb_sar_ctrl;
  import sar_pkg::*;

  localparam int NB     = 8;
  localparam int SC     = 2;
  localparam int DONE_N = SC + 2 * NB + 1;

  typedef struct {
    logic [7:0] vin;
    bit         pulses;
    logic [7:0] exp_result;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       comp_out;
  logic       sample;
  logic       comp_en;
  logic [7:0] dac;
  logic       busy;
  logic       done;
  logic [7:0] result;
  sar_state_e dbg_state;

  logic [7:0] vin;
  logic [7:0] last_result;
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  logic       prev_rst;
  logic       prev_done;
  logic       prev_comp;
  logic [7:0] prev_dac;
  vec_t       vecs[6];

  sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .comp_out  (comp_out),
    .sample    (sample),
    .comp_en   (comp_en),
    .dac       (dac),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: decision registered on the edge that closes the CMP cycle.
  initial comp_out = 1'b0;
  always @(posedge clk) begin
    if (comp_en) comp_out <= (vin >= dac);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and apply the always-on invariants.
  task automatic tick();
    @(negedge clk);
    if (rst_n && prev_rst) begin
      check("no_overlap", 32'(sample & comp_en), 32'd0);
      if (prev_done) check("done_width", 32'(done), 32'd0);
      if (prev_comp) check("dac_stable", 32'(dac), 32'(prev_dac));
    end
    prev_rst  = rst_n;
    prev_done = done;
    prev_comp = comp_en;
    prev_dac  = dac;
  endtask

  // Binary search over the code space: trial sequence and final code.
  function automatic logic [7:0] ref_model(input logic [7:0] v);
    logic [7:0] code;
    logic [7:0] tr;
    code = 8'd0;
    exp_q.delete();
    for (int b = NB - 1; b >= 0; b--) begin
      tr = code | (8'd1 << b);
      exp_q.push_back(tr);
      if (v >= tr) code = tr;
    end
    return code;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample"}, 32'(sample), 32'd0);
    check({tag, "_comp_en"}, 32'(comp_en), 32'd0);
    check({tag, "_dac"}, 32'(dac), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
  endtask

  // One conversion, checked cycle by cycle against the documented timeline.
  task automatic conv(input logic [7:0] v, input logic [7:0] exp_res, input bit pulses,
                      input bit chained, input bit keep);
    logic [7:0] e_dac;
    void'(ref_model(v));
    vin = v;
    if (!chained) begin
      tick();
      start = 1'b1;
    end
    @(posedge clk);
    for (int n = 1; n <= DONE_N + 1; n++) begin
      tick();
      e_dac = (n >= SC + 1 && n <= SC + 2 * NB) ? exp_q[(n - SC - 1) / 2] : 8'd0;
      check("sample", 32'(sample), 32'(n <= SC));
      check("comp_en", 32'(comp_en), 32'(n >= SC + 1 && n <= SC + 2 * NB && ((n - SC - 1) % 2 == 0)));
      check("dac", 32'(dac), 32'(e_dac));
      check("done", 32'(done), 32'(n == DONE_N));
      check("busy", 32'(busy), 32'(n <= DONE_N));
      check("result", 32'(result), 32'((n >= DONE_N) ? exp_res : last_result));
      start = keep || (pulses && (n == 5 || n == 18));
    end
    last_result = exp_res;
  endtask

  initial begin
    logic [7:0] rv;
    n_checks    = 0;
    n_fail      = 0;
    prev_rst    = 1'b0;
    prev_done   = 1'b0;
    prev_comp   = 1'b0;
    prev_dac    = 8'd0;
    last_result = 8'd0;
    rst_n       = 1'b0;
    start       = 1'b0;
    vin         = 8'd0;

    vecs[0] = '{vin: 8'hA5, pulses: 1'b0, exp_result: 8'hA5};
    vecs[1] = '{vin: 8'h00, pulses: 1'b0, exp_result: 8'h00};
    vecs[2] = '{vin: 8'hFF, pulses: 1'b0, exp_result: 8'hFF};
    vecs[3] = '{vin: 8'h3C, pulses: 1'b1, exp_result: 8'h3C};
    vecs[4] = '{vin: 8'h80, pulses: 1'b0, exp_result: 8'h80};
    vecs[5] = '{vin: 8'h7F, pulses: 1'b1, exp_result: 8'h7F};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    tick();
    rst_n = 1'b1;

    // Reset asserted mid-conversion: outputs clear without waiting for a clock.
    vin = 8'h5A;
    tick();
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      tick();
      start = 1'b0;
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    check_outputs_zero("in_rst");
    rst_n = 1'b1;
    conv(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      conv(vecs[i].vin, vecs[i].exp_result, vecs[i].pulses, 1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      rv = 8'($urandom_range(0, 255));
      conv(rv, ref_model(rv), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // start held high: three conversions on a 20-cycle cadence.
    conv(8'h12, 8'h12, 1'b0, 1'b0, 1'b1);
    conv(8'hC3, 8'hC3, 1'b0, 1'b1, 1'b1);
    conv(8'h69, 8'h69, 1'b0, 1'b1, 1'b0);

    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_result", 32'(result), 32'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
